// File: rtl/bit_stream_serializer_if.sv
// Load handshake and serial output bundle for bit_stream_serializer.
// The master side (a producer or bench) offers words; the slave side (the
// serializer) accepts them and drives the serial stream and status flags.
interface bit_stream_serializer_if #(
  parameter int WIDTH = 8
);

  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             data_out;
  logic             bit_strobe;
  logic             busy;
  logic             done;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  data_out,
    input  bit_strobe,
    input  busy,
    input  done
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output data_out,
    output bit_strobe,
    output busy,
    output done
  );

endinterface

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial source for the lab sequence detectors.
// A WIDTH-bit word is accepted through a valid/ready handshake and shifted
// out one bit per TICK_DIV clocks, MSB first unless LSB_FIRST is set.
// bit_strobe marks the last clock of each bit period; done pulses for one
// cycle after the final bit. Every output is a flop, so there is no
// combinational path from the load inputs to any output.
//
// Optional feature: define SERIALIZER_REPEAT_EN to add the repeat_frame
// input. When it is high on the final strobe edge of a frame, the word is
// reloaded from the hold register and re-sent with no gap and no done pulse.
// (The keyword 'repeat' cannot be used as a port name, hence repeat_frame.)
module bit_stream_serializer #(
  parameter int WIDTH     = 8,
  parameter int TICK_DIV  = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic clk,
  input  logic reset_n,
`ifdef SERIALIZER_REPEAT_EN
  input  logic repeat_frame,
`endif
  bit_stream_serializer_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(WIDTH);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam bit            LSB       = (LSB_FIRST != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [TW-1:0]    tick_cnt;
  logic [TW-1:0]    tick_nxt;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_nxt;

`ifdef SERIALIZER_REPEAT_EN
  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] hold_nxt;
`endif

  logic load_ready_q;
  logic data_out_q;
  logic bit_strobe_q;
  logic busy_q;
  logic done_q;

  logic [WIDTH-1:0] shreg_shifted;
  logic             data_bit_nxt;

  assign shreg_shifted = LSB ? (shreg >> 1) : (shreg << 1);
  assign data_bit_nxt  = LSB ? shreg_nxt[0] : shreg_nxt[WIDTH-1];

  // Next-state decode for the FSM, shift register and both counters.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
`ifdef SERIALIZER_REPEAT_EN
    hold_nxt  = hold_reg;
`endif
    unique case (state)
      IDLE: begin
        if (bus.load_valid) begin
          state_nxt = SHIFT;
          shreg_nxt = bus.load_data;
`ifdef SERIALIZER_REPEAT_EN
          hold_nxt  = bus.load_data;
`endif
          tick_nxt  = '0;
          bit_nxt   = '0;
        end
      end
      SHIFT: begin
        if (tick_cnt == TICK_LAST) begin
          tick_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
`ifdef SERIALIZER_REPEAT_EN
            if (repeat_frame) begin
              shreg_nxt = hold_reg;
              bit_nxt   = '0;
            end else begin
              state_nxt = DONE;
              shreg_nxt = '0;
              bit_nxt   = '0;
            end
`else
            state_nxt = DONE;
            shreg_nxt = '0;
            bit_nxt   = '0;
`endif
          end else begin
            shreg_nxt = shreg_shifted;
            bit_nxt   = bit_cnt + BW'(1);
          end
        end else begin
          tick_nxt = tick_cnt + TW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs are derived from next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      shreg        <= '0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
`ifdef SERIALIZER_REPEAT_EN
      hold_reg     <= '0;
`endif
      load_ready_q <= 1'b1;
      data_out_q   <= 1'b0;
      bit_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      tick_cnt     <= tick_nxt;
      bit_cnt      <= bit_nxt;
`ifdef SERIALIZER_REPEAT_EN
      hold_reg     <= hold_nxt;
`endif
      load_ready_q <= (state_nxt == IDLE);
      data_out_q   <= (state_nxt == SHIFT) ? data_bit_nxt : 1'b0;
      bit_strobe_q <= (state_nxt == SHIFT) && (tick_nxt == TICK_LAST);
      busy_q       <= (state_nxt == SHIFT);
      done_q       <= (state_nxt == DONE);
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.data_out   = data_out_q;
  assign bus.bit_strobe = bit_strobe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
